io_master_seq: RTL and testbench



---
 rtl/io_master_seq.sv | 112 +++++++++++
 tb/tb_io_master_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/io_master_seq.sv
// io_master_seq: IO-bus initiator issuing single/burst client requests as one-hot-sized IO-bus beats
// Ports: AClkH/AResetHN/AClkHEn clocking; AReq* burst request; AWrData* write beats;
//        ARsp* one response per beat; AIo* bus address/data/size and responder ack/err; ABusy not idle
module io_master_seq #(
  parameter int CBurstW     = 8,
  parameter bit CAddrStepEn = 1'b1
) (
  input  logic               AClkH,
  input  logic               AResetHN,
  input  logic               AClkHEn,
  input  logic               AReqValid,
  output logic               AReqReady,
  input  logic               AReqWr,
  input  logic [1:0]         AReqSize,
  input  logic [15:0]        AReqAddr,
  input  logic [CBurstW-1:0] AReqCnt,
  input  logic               AWrDataValid,
  output logic               AWrDataReady,
  input  logic [63:0]        AWrData,
  output logic               ARspValid,
  input  logic               ARspReady,
  output logic [63:0]        ARspData,
  output logic               ARspErr,
  output logic               ARspLast,
  output logic [15:0]        AIoAddr,
  output logic [63:0]        AIoMosi,
  output logic [3:0]         AIoWrSize,
  output logic [3:0]         AIoRdSize,
  input  logic [63:0]        AIoMiso,
  input  logic               AIoAddrAck,
  input  logic               AIoAddrErr,
  output logic               ABusy
);
  typedef enum logic [1:0] {IDLE, WDATA, ACCESS, RESP} state_t;
  state_t state_q, state_d;
  logic armed_q, armed_d;
  logic wr_q, wr_d;
  logic [1:0] size_q, size_d;
  logic [15:0] addr_q, addr_d;
  logic [CBurstW-1:0] rem_q, rem_d;
  logic [63:0] data_q, data_d;
  logic err_q, err_d;
  logic [63:0] mask;
  logic [3:0] onehot;
  logic last, acc;
  always_comb begin
    mask = size_q == 2'd0 ? 64'hFF : size_q == 2'd1 ? 64'hFFFF : size_q == 2'd2 ? 64'hFFFF_FFFF : '1;
    onehot = 4'b0001 << size_q;
    last = rem_q == '0 || err_q;
    acc = state_q == ACCESS;
    state_d = state_q;
    armed_d = 1'b1;
    wr_d = wr_q;
    size_d = size_q;
    addr_d = addr_q;
    rem_d = rem_q;
    data_d = data_q;
    err_d = err_q;
    if (state_q == IDLE && armed_q && AReqValid) begin
      wr_d = AReqWr;
      size_d = AReqSize;
      addr_d = AReqAddr;
      rem_d = AReqCnt;
      state_d = AReqWr ? WDATA : ACCESS;
    end
    if (state_q == WDATA && AWrDataValid) begin
      data_d = AWrData & mask;
      state_d = ACCESS;
    end
    if (acc) begin
      data_d = wr_q ? '0 : AIoMiso & mask;
      err_d = !AIoAddrAck || AIoAddrErr;
      state_d = RESP;
    end
    if (state_q == RESP && ARspReady) begin
      state_d = last ? IDLE : wr_q ? WDATA : ACCESS;
      rem_d = last ? rem_q : rem_q - 1'b1;
      addr_d = (last || !CAddrStepEn) ? addr_q : addr_q + (16'd1 << size_q);
    end
  end
  always_ff @(posedge AClkH or negedge AResetHN)
    if (!AResetHN) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      wr_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      rem_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else if (AClkHEn) begin
      state_q <= state_d;
      armed_q <= armed_d;
      wr_q <= wr_d;
      size_q <= size_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  assign AReqReady = armed_q && state_q == IDLE;
  assign AWrDataReady = state_q == WDATA;
  assign ARspValid = state_q == RESP;
  assign ARspData = ARspValid ? data_q : '0;
  assign ARspErr = ARspValid && err_q;
  assign ARspLast = ARspValid && last;
  assign AIoAddr = acc ? addr_q : '0;
  assign AIoMosi = acc && wr_q ? data_q : '0;
  assign AIoWrSize = acc && wr_q ? onehot : '0;
  assign AIoRdSize = acc && !wr_q ? onehot : '0;
  assign ABusy = state_q != IDLE;
endmodule

// File: tb/tb_io_master_seq.sv
// tb_io_master_seq: randomized burst traffic against a queue-based model of the IO-bus initiator
module tb_io_master_seq;
  logic AClkH = 0, AResetHN = 0, AClkHEn = 0;
  logic AReqValid = 0, AReqReady, AReqWr = 0;
  logic [1:0] AReqSize = 0;
  logic [15:0] AReqAddr = 0;
  logic [7:0] AReqCnt = 0;
  logic AWrDataValid = 0, AWrDataReady;
  logic [63:0] AWrData = 0;
  logic ARspValid, ARspReady = 0, ARspErr, ARspLast;
  logic [63:0] ARspData;
  logic [15:0] AIoAddr;
  logic [63:0] AIoMosi, AIoMiso;
  logic [3:0] AIoWrSize, AIoRdSize;
  logic AIoAddrAck, AIoAddrErr, ABusy;
  int checks = 0, errors = 0;
  logic nak_en = 0, err_en = 0;
  logic [15:0] nak_addr = 0, err_addr = 0;
  logic [63:0] miso_base = 0;
  logic [15:0] m_addr[$];
  logic [3:0] m_wsz[$], m_rsz[$];
  logic [63:0] m_mosi[$];
  io_master_seq dut (
    .AClkH(AClkH), .AResetHN(AResetHN), .AClkHEn(AClkHEn),
    .AReqValid(AReqValid), .AReqReady(AReqReady), .AReqWr(AReqWr), .AReqSize(AReqSize),
    .AReqAddr(AReqAddr), .AReqCnt(AReqCnt),
    .AWrDataValid(AWrDataValid), .AWrDataReady(AWrDataReady), .AWrData(AWrData),
    .ARspValid(ARspValid), .ARspReady(ARspReady), .ARspData(ARspData), .ARspErr(ARspErr),
    .ARspLast(ARspLast), .AIoAddr(AIoAddr), .AIoMosi(AIoMosi), .AIoWrSize(AIoWrSize),
    .AIoRdSize(AIoRdSize), .AIoMiso(AIoMiso), .AIoAddrAck(AIoAddrAck), .AIoAddrErr(AIoAddrErr),
    .ABusy(ABusy)
  );
  always #5 AClkH = ~AClkH;
  always_comb begin
    AIoAddrAck = !(nak_en && AIoAddr == nak_addr);
    AIoAddrErr = err_en && AIoAddr == err_addr;
    AIoMiso = AIoAddrAck ? miso_base + {AIoAddr, 48'h0} : '0;
  end
  always @(posedge AClkH)
    if (AResetHN && AClkHEn && (AIoWrSize != 0 || AIoRdSize != 0)) begin
      m_addr.push_back(AIoAddr);
      m_wsz.push_back(AIoWrSize);
      m_rsz.push_back(AIoRdSize);
      m_mosi.push_back(AIoMosi);
    end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] msk(input logic [1:0] s);
    return s == 0 ? 64'hFF : s == 1 ? 64'hFFFF : s == 2 ? 64'hFFFF_FFFF : '1;
  endfunction
  task automatic run_burst(input logic wr, input logic [1:0] sz, input logic [15:0] ad,
                           input logic [7:0] cnt, input int hold, input bit rnd);
    logic [63:0] wd[$], ed[$];
    logic [15:0] ea[$];
    logic ee[$];
    logic [15:0] a;
    logic nak, bad;
    int n, ri = 0, wi = 0, hc = 0;
    bit req = 1, en, rdy, wv;
    for (int i = 0; i <= int'(cnt); i++) begin
      a = ad + 16'(i * (1 << sz));
      nak = nak_en && a == nak_addr;
      bad = nak || (err_en && a == err_addr);
      wd.push_back({$urandom, $urandom});
      ea.push_back(a);
      ee.push_back(bad);
      ed.push_back(wr || nak ? 64'h0 : (miso_base + {a, 48'h0}) & msk(sz));
      if (bad) break;
    end
    n = ea.size();
    m_addr.delete(); m_wsz.delete(); m_rsz.delete(); m_mosi.delete();
    for (int c = 0; c < 4000 && ri < n; c++) begin
      @(negedge AClkH);
      en = rnd ? $urandom_range(0, 3) != 0 : 1'b1;
      AClkHEn = en;
      AReqValid = req; AReqWr = wr; AReqSize = sz; AReqAddr = ad; AReqCnt = cnt;
      if (req && AReqReady && en) req = 0;
      wv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      AWrDataValid = wv;
      AWrData = wd[wi < n ? wi : n - 1];
      if (wv && AWrDataReady && en) wi++;
      if (ARspValid) begin
        chk("rsp_data", ARspData, ed[ri]);
        chk("rsp_err", ARspErr, ee[ri]);
        chk("rsp_last", ARspLast, ee[ri] || ri == int'(cnt));
        rdy = hc >= hold && (rnd ? $urandom_range(0, 1) == 1 : 1'b1);
        hc++;
        ARspReady = rdy;
        if (rdy && en) begin ri++; hc = 0; end
      end else ARspReady = 1'($urandom_range(0, 1));
    end
    if (ri < n) chk("rsp_timeout", ri, n);
    @(negedge AClkH);
    AClkHEn = 1; AReqValid = 0; AWrDataValid = 0; ARspReady = 0;
    repeat (3) @(negedge AClkH);
    chk("idle_busy", ABusy, 0);
    chk("idle_ready", AReqReady, 1);
    chk("acc_count", m_addr.size(), n);
    chk("wr_consumed", wi, wr ? n : 0);
    for (int i = 0; i < n && i < m_addr.size(); i++) begin
      chk("bus_addr", m_addr[i], ea[i]);
      chk("bus_wsz", m_wsz[i], wr ? 4'b0001 << sz : 4'b0);
      chk("bus_rsz", m_rsz[i], wr ? 4'b0 : 4'b0001 << sz);
      if (wr) chk("bus_mosi", m_mosi[i], wd[i] & msk(sz));
    end
  endtask
  initial begin
    #12;
    chk("rst_reqrdy", AReqReady, 0);
    chk("rst_wrrdy", AWrDataReady, 0);
    chk("rst_rspv", {ARspValid, ARspErr, ARspLast}, 0);
    chk("rst_rspdata", ARspData, 0);
    chk("rst_bus", {AIoAddr, AIoWrSize, AIoRdSize}, 0);
    chk("rst_mosi", AIoMosi, 0);
    chk("rst_busy", ABusy, 0);
    @(negedge AClkH) AResetHN = 1;
    @(negedge AClkH) chk("rdy_before_en", AReqReady, 0);
    AClkHEn = 1;
    @(negedge AClkH) chk("rdy_after_en", AReqReady, 1);
    miso_base = 64'hDEADBEEF_12345678;
    run_burst(0, 2, 16'h0010, 0, 0, 0);
    run_burst(1, 1, 16'h0100, 2, 0, 0);
    nak_en = 1; nak_addr = 16'h0300;
    run_burst(0, 3, 16'h0300, 0, 0, 0);
    nak_en = 0; err_en = 1; err_addr = 16'h0204;
    run_burst(0, 2, 16'h0200, 3, 0, 0);
    err_en = 0;
    run_burst(0, 1, 16'hFFFE, 1, 5, 1);
    run_burst(1, 1, 16'hFFFE, 1, 5, 1);
    for (int t = 0; t < 30; t++) begin
      logic [1:0] sz;
      logic [15:0] ad;
      logic [7:0] cn;
      sz = 2'($urandom_range(0, 3));
      ad = 16'($urandom);
      cn = 8'($urandom_range(0, 5));
      miso_base = {$urandom, $urandom};
      nak_en = $urandom_range(0, 4) == 0;
      nak_addr = ad + 16'($urandom_range(0, 5) * (1 << sz));
      err_en = $urandom_range(0, 4) == 0;
      err_addr = ad + 16'($urandom_range(0, 5) * (1 << sz));
      run_burst(1'($urandom_range(0, 1)), sz, ad, cn, $urandom_range(0, 3), 1);
    end
    nak_en = 0; err_en = 0;
    @(negedge AClkH);
    AClkHEn = 1; AReqValid = 1; AReqWr = 0; AReqSize = 3; AReqAddr = 16'h0040; AReqCnt = 0;
    @(negedge AClkH);
    AReqValid = 0; AClkHEn = 0;
    repeat (3) @(negedge AClkH);
    chk("held_rsz", AIoRdSize, 4'b1000);
    chk("held_addr", AIoAddr, 16'h0040);
    #2 AResetHN = 0;
    #1;
    chk("arst_rsz", AIoRdSize, 0);
    chk("arst_addr", AIoAddr, 0);
    chk("arst_busy", ABusy, 0);
    chk("arst_reqrdy", AReqReady, 0);
    @(negedge AClkH) AResetHN = 1;
    @(negedge AClkH) chk("rel_rdy_before_en", AReqReady, 0);
    AClkHEn = 1;
    @(negedge AClkH) chk("rel_rdy_after_en", AReqReady, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
